rep7_encoder_tx: RTL and testbench
==================================

# rep7_encoder_tx

Time-redundant repetition-code transmitter. Accepts parallel data words over a valid/ready handshake and serializes them LSB-first, emitting each bit as REPS consecutive identical beats on a 1-bit valid/ready stream. It is the sending end of the repetition link whose receiving end is the combinational 7-input majority voter: the receiver collects the REPS copies of a bit and votes them back to one bit.

## Interface
Parameters:
- DATA_W, 8, data word width in bits; must be ≥ 1.
- REPS, 7, copies per bit; must be odd and ≥ 3. The default 7 matches the 7-input majority voter.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word to transmit; sampled on the in_valid && in_ready edge.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  current copy of the current data bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts the beat.
- out_first  output  1  beat is copy 0 of a bit (receiver voter window start).
- out_last  output  1  beat is copy REPS-1 of bit DATA_W-1 (end of word).

## Operation
- States:
  - IDLE: no word held.
  - SEND: word held in shift register `sreg`; counters `rep_cnt` (0..REPS-1) and `bit_cnt` (0..DATA_W-1).
- Transitions and counting:
  - IDLE → SEND on accept. Load sreg = in_data and clear both counters.
  - A beat handshake is out_valid && out_ready. On each handshake in SEND, rep_cnt increments.
  - When rep_cnt wraps from REPS-1 to 0, sreg shifts right by 1 and bit_cnt increments.
  - Final beat: rep_cnt == REPS-1 and bit_cnt == DATA_W-1.
  - Handshake on the final beat goes to IDLE, or reloads SEND directly if a new word is accepted in the same cycle.
- Outputs:
  - out_valid = (state == SEND).
  - out_bit = sreg[0].
  - out_first = SEND && rep_cnt == 0.
  - out_last = SEND && final beat.
- in_ready = (state == IDLE) || (final beat && out_ready). This is combinational and allows zero-bubble back-to-back words.
- One word costs exactly DATA_W*REPS beat handshakes (56 at defaults).
- When the stream is stalled (out_valid && !out_ready), out_bit, out_first and out_last hold stable and no counter moves.
- in_valid while in_ready is low is ignored; upstream must hold the word.
- in_data is not required to stay stable after the accept edge.
- Counter widths: clog2(REPS) and clog2(DATA_W), with a minimum of 1 bit each. Counters never reach values outside their ranges.

## Timing
- Reset values (rst_n low, asynchronous): state IDLE, sreg 0, counters 0.
  - Therefore out_valid 0, out_bit 0, out_first 0, out_last 0.
  - in_ready reads 1 once in IDLE.
- Latency: word accepted at edge t; out_valid = 1 and copy 0 of bit 0 are present in cycle t+1, independent of out_ready.
- Back-to-back words: the final-beat handshake and the next accept happen on the same edge. The next cycle shows copy 0 of bit 0 of the new word with out_first = 1.
- Reset mid-word: the word in flight is discarded and out_valid drops asynchronously. After release, the next accepted word starts at bit 0, copy 0.
- in_valid and out_ready rising together while in IDLE: the word is accepted; out_ready has no effect until the next cycle.

## Structure
- Shared package `rep_code_pkg`:
  - REPS_DEFAULT = 7 and DATA_W_DEFAULT = 8.
  - State enum `rep_tx_state_t` {IDLE, SEND}.
  - A clog2 helper with a minimum result of 1.
- These are reused by the receive-side framer that feeds the majority voter.
- One sub-module is natural: `rep_beat_ctr`, the nested rep/bit counter. Inputs: advance, load. Outputs: rep_cnt, bit_cnt, bit_wrap, final. The top level keeps the FSM, shift register and handshake logic.
- Estimated size: about 150–200 lines RTL total.

## Test plan
- Reset, send 0xA5 with out_ready held at 1:
  - Exactly 56 beats in the sequence 1×7, 0×7, 1×7, 0×7, 0×7, 1×7, 0×7, 1×7.
  - out_first on beats 0, 7, …, 49; out_last only on beat 55.
  - in_ready = 0 during beats 0–54.
- Back-to-back 0x01 then 0xFF with in_valid held at 1:
  - 0xFF is accepted on the beat-55 handshake.
  - Beat 56 = 1 with out_first = 1; no idle cycle between words.
- Backpressure, out_ready = 1,0,1,0,… while sending 0x3C:
  - Outputs stable across every stalled cycle.
  - 56 handshakes total; the handshake sequence equals the unstalled reference.
- Assert rst_n = 0 after 20 beats of 0xFF:
  - out_valid goes to 0 the same cycle without a clock edge.
  - After release, in_ready = 1.
  - Word 0x02 then produces 0×7, then 1×7, …
- Loopback through a 7-input majority voter, windowed by out_first, with up to 3 of the 7 copies of each bit randomly inverted over 1000 words: every decoded word equals its sent word.
- IDLE, out_ready = 0, then in_valid pulsed with 0x80:
  - Accepted; out_valid = 1 with out_bit = 0 and out_first = 1 from the next cycle.
  - These values hold unchanged until out_ready rises.

Source files
------------

// File: rtl/rep_code_pkg.sv
// ---------------------------------------------------------------------------
// rep_code_pkg
// Shared definitions for the repetition-code link. The transmitter
// (rep7_encoder_tx) uses them, and so does the receive-side framer that feeds
// the 7-input majority voter.
//   REPS_DEFAULT   : copies per bit; the voter takes 7 inputs.
//   DATA_W_DEFAULT : data word width in bits.
//   rep_tx_state_t : transmitter FSM states.
//   clog2_min1     : counter width helper. It never returns less than 1 bit.
// ---------------------------------------------------------------------------
package rep_code_pkg;

    localparam int REPS_DEFAULT   = 7;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rep_tx_state_t;

    // $clog2(1) is 0. A zero-width counter is not legal, so clamp to 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rep_beat_ctr.sv
// ---------------------------------------------------------------------------
// rep_beat_ctr
// Nested beat counter for the repetition transmitter.
// rep_cnt counts the copies of the current bit (0..REPS-1).
// bit_cnt counts the data bits of the word (0..DATA_W-1).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_advance    : a beat handshake happened this cycle
//   i_load       : a new word is accepted; clears both counters (takes priority)
//   o_rep_cnt    : copy index of the current beat
//   o_bit_cnt    : bit index of the current beat
//   o_bit_wrap   : this handshake is the last copy of a bit (the data shifts)
//   o_final      : the current beat is the last copy of the last bit
// ---------------------------------------------------------------------------
module rep_beat_ctr
    import rep_code_pkg::*;
#(
    parameter  int REPS   = REPS_DEFAULT,
    parameter  int DATA_W = DATA_W_DEFAULT,
    localparam int REP_W  = clog2_min1(REPS),
    localparam int BIT_W  = clog2_min1(DATA_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_advance,
    input  logic             i_load,
    output logic [REP_W-1:0] o_rep_cnt,
    output logic [BIT_W-1:0] o_bit_cnt,
    output logic             o_bit_wrap,
    output logic             o_final
);

    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPS - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             w_rep_max;
    logic             w_bit_max;

    assign w_rep_max = (r_rep_cnt == REP_MAX);
    assign w_bit_max = (r_bit_cnt == BIT_MAX);

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (i_advance) begin
            if (w_rep_max) begin
                r_rep_cnt <= '0;
                // On the final beat bit_cnt wraps explicitly. For a DATA_W that
                // is not a power of two it would otherwise leave its range.
                r_bit_cnt <= w_bit_max ? '0 : r_bit_cnt + 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    assign o_rep_cnt  = r_rep_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_bit_wrap = i_advance && w_rep_max;
    assign o_final    = w_rep_max && w_bit_max;

endmodule

// File: rtl/rep7_encoder_tx.sv
// ---------------------------------------------------------------------------
// rep7_encoder_tx
// Time-redundant repetition-code transmitter. It accepts a parallel word and
// sends it LSB-first. Each bit goes out as REPS identical beats, so the
// receiver's majority voter can vote out up to (REPS-1)/2 corrupted copies.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_data     : word to send; sampled on the in_valid && in_ready edge
//   in_valid    : upstream word valid
//   in_ready    : a word can be accepted this cycle (combinational)
//   out_bit     : current copy of the current data bit
//   out_valid   : out_bit is valid
//   out_ready   : downstream accepts the beat
//   out_first   : copy 0 of a bit (start of the voter window)
//   out_last    : last copy of the last bit (end of word)
// ---------------------------------------------------------------------------
module rep7_encoder_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REPS   = REPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last
);

    localparam int REP_W = clog2_min1(REPS);
    localparam int BIT_W = clog2_min1(DATA_W);

    rep_tx_state_t     r_state;
    rep_tx_state_t     w_state_nxt;
    logic [DATA_W-1:0] r_sreg;

    logic [REP_W-1:0]  w_rep_cnt;
    logic [BIT_W-1:0]  w_bit_cnt;
    logic              w_bit_wrap;
    logic              w_final;
    logic              w_send;
    logic              w_beat;
    logic              w_final_beat;
    logic              w_accept;

    assign w_send       = (r_state == SEND);
    assign w_beat       = w_send && out_ready;
    assign w_final_beat = w_send && w_final;
    assign w_accept     = in_valid && in_ready;

    // Ready in IDLE, or while the last beat is being taken. A new word can
    // then follow the old one with no idle cycle in between.
    assign in_ready = !w_send || (w_final_beat && out_ready);

    rep_beat_ctr #(
        .REPS   (REPS),
        .DATA_W (DATA_W)
    ) u_beat_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_advance  (w_beat),
        .i_load     (w_accept),
        .o_rep_cnt  (w_rep_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_wrap (w_bit_wrap),
        .o_final    (w_final)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assigned first so that no path through the case infers a latch.
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_beat && w_final) begin
                    w_state_nxt = w_accept ? SEND : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new word takes priority over the final shift of the old one. After a
    // complete word every bit has been shifted out, so sreg rests at 0 in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (w_accept) begin
            r_sreg <= in_data;
        end else if (w_bit_wrap) begin
            r_sreg <= r_sreg >> 1;
        end
    end

    assign out_valid = w_send;
    assign out_bit   = r_sreg[0];
    assign out_first = w_send && (w_rep_cnt == '0);
    assign out_last  = w_final_beat;

    // Both counters stay in range, and they rest at zero whenever no word is held.
    a_ctr_range : assert property (@(posedge clk) disable iff (!rst_n)
        (w_rep_cnt <= REP_W'(REPS - 1)) && (w_bit_cnt <= BIT_W'(DATA_W - 1)));
    a_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
        !w_send |-> (w_rep_cnt == '0) && (w_bit_cnt == '0));

endmodule

// File: tb/tb_rep7_encoder_tx.sv
// ---------------------------------------------------------------------------
// tb_rep7_encoder_tx
// Self-checking bench for rep7_encoder_tx at its default parameters
// (8-bit words, 7 copies per bit).
// ---------------------------------------------------------------------------
module tb_rep7_encoder_tx;

    localparam int DW    = 8;
    localparam int REPS  = 7;
    localparam int BEATS = DW * REPS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_bit;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;

    always #5 clk = ~clk;

    rep7_encoder_tx #(
        .DATA_W (DW),
        .REPS   (REPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard. On each falling edge it checks every beat handshake
    // against the expected words, and checks that outputs hold steady
    // across stalls.
    // ------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    int            beat_idx      = 0;
    int            hs_total      = 0;
    int            ones_cnt      = 0;
    logic          last_bit_seen = 1'bx;
    logic          prev_stall    = 1'b0;
    logic          prev_bit, prev_first, prev_last;

    // Loopback decoder: inject up to 3 inverted copies per bit, then vote.
    bit            lb_en    = 1'b0;
    logic [DW-1:0] lb_sent_q[$];
    logic [6:0]    lb_mask;
    logic [6:0]    lb_win;
    logic [DW-1:0] lb_dec;
    int            lb_copy  = 0;
    int            lb_bit   = 0;
    int            lb_words = 0;

    always @(negedge clk) begin : monitor
        logic [DW-1:0] w;
        if (!rst_n) begin
            exp_q.delete();
            beat_idx   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_bit, out_first, out_last},
                      {1'b1, prev_bit, prev_first, prev_last});
            if (out_valid && out_ready) begin
                hs_total++;
                ones_cnt += int'(out_bit);
                if (out_last) last_bit_seen = out_bit;
                if (exp_q.size() == 0) begin
                    check("beat_without_word", out_valid, 1'b0);
                end else begin
                    w = exp_q[0];
                    check($sformatf("beat%0d", beat_idx),
                          {out_bit, out_first, out_last, in_ready},
                          {w[beat_idx / REPS], (beat_idx % REPS) == 0,
                           beat_idx == BEATS - 1, beat_idx == BEATS - 1});
                    beat_idx++;
                    if (beat_idx == BEATS) begin
                        void'(exp_q.pop_front());
                        beat_idx = 0;
                    end
                end
                if (lb_en) begin
                    if (out_first) begin
                        lb_copy = 0;
                        do lb_mask = 7'($urandom_range(0, 127));
                        while ($countones(lb_mask) > 3);
                    end
                    lb_win[lb_copy] = out_bit ^ lb_mask[lb_copy];
                    lb_copy++;
                    if (lb_copy == REPS) begin
                        lb_dec[lb_bit] = ($countones(lb_win) >= 4);
                        lb_bit++;
                        lb_copy = 0;
                    end
                    if (out_last) begin
                        if (lb_sent_q.size() == 0)
                            check("lb_unexpected_word", 32'(lb_sent_q.size()), 1);
                        else
                            check("lb_word", lb_dec, lb_sent_q.pop_front());
                        lb_words++;
                        lb_bit = 0;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            prev_first = out_first;
            prev_last  = out_last;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [DW-1:0] word);
        logic acc;
        acc      = 1'b0;
        in_data  = word;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        check("accept_in_time", acc, 1'b1);
    endtask

    task automatic drain(input bit stall_mode);
        int n;
        n = 0;
        while (out_valid && n < 400) begin
            out_ready = stall_mode ? (n % 2 == 0) : 1'b1;
            step();
            n++;
        end
        out_ready = 1'b1;
        check("drain_idle", out_valid, 1'b0);
        check("drain_sb_empty", 32'(exp_q.size()), 0);
    endtask

    typedef struct {
        logic [DW-1:0] word;
        bit            stall;
        int            exp_ones;
        logic          exp_last_bit;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int hs0;
        int cyc;
        int sent;

        // Expected values worked out by hand: ones = popcount * 7, last = MSB.
        vecs[0] = '{8'hA5, 1'b0, 28, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 28, 1'b0};
        vecs[2] = '{8'h00, 1'b0,  0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 56, 1'b1};
        vecs[4] = '{8'h01, 1'b0,  7, 1'b0};
        vecs[5] = '{8'h80, 1'b1,  7, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("reset_outputs", {out_valid, out_bit, out_first, out_last}, 4'b0000);
        check("reset_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);

        // Table of single words. in_valid and out_ready rise together in IDLE.
        foreach (vecs[k]) begin
            hs0           = hs_total;
            ones_cnt      = 0;
            last_bit_seen = 1'bx;
            out_ready     = 1'b1;
            accept_word(vecs[k].word);
            drain(vecs[k].stall);
            check($sformatf("v%0d_handshakes", k), 32'(hs_total - hs0), BEATS);
            check($sformatf("v%0d_ones", k), 32'(ones_cnt), 32'(vecs[k].exp_ones));
            check($sformatf("v%0d_last_bit", k), last_bit_seen, vecs[k].exp_last_bit);
        end

        // Back-to-back: 0x01 then 0xFF, with in_valid held high throughout.
        hs0       = hs_total;
        out_ready = 1'b1;
        in_data   = 8'h01;
        in_valid  = 1'b1;
        #1;
        check("b2b_ready_idle", in_ready, 1'b1);
        step();
        in_data = 8'hFF;
        cyc     = 0;
        while (cyc < 100) begin
            #1;
            if (out_last) break;
            step();
            cyc++;
        end
        check("b2b_last_beat_index", 32'(cyc), BEATS - 1);
        check("b2b_ready_on_last", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        check("b2b_beat56", {out_valid, out_first, out_bit}, 3'b111);
        drain(1'b0);
        check("b2b_handshakes", 32'(hs_total - hs0), 2 * BEATS);

        // Reset after 20 beats of 0xFF.
        hs0       = hs_total;
        out_ready = 1'b1;
        accept_word(8'hFF);
        repeat (20) step();
        check("rst_beats_before", 32'(hs_total - hs0), 20);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {out_valid, out_first, out_last}, 3'b000);
        #10;
        step();
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {in_ready, out_valid}, 2'b10);
        hs0           = hs_total;
        ones_cnt      = 0;
        last_bit_seen = 1'bx;
        accept_word(8'h02);
        drain(1'b0);
        check("rst_next_handshakes", 32'(hs_total - hs0), BEATS);
        check("rst_next_ones", 32'(ones_cnt), 7);

        // Latency with out_ready low: 0x80 pulsed while in IDLE.
        out_ready = 1'b0;
        in_data   = 8'h80;
        in_valid  = 1'b1;
        #1;
        check("lat_ready_idle", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_data  = 8'h55;
        #1;
        check("lat_first_beat", {out_valid, out_bit, out_first, out_last}, 4'b1010);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("lat_hold%0d", i), {out_valid, out_bit, out_first, out_last}, 4'b1010);
        end
        ones_cnt      = 0;
        last_bit_seen = 1'bx;
        drain(1'b0);
        check("lat_ones", 32'(ones_cnt), 7);
        check("lat_last_bit", last_bit_seen, 1'b1);

        // Loopback through a majority voter, with injected copy errors.
        lb_en     = 1'b1;
        lb_bit    = 0;
        lb_copy   = 0;
        lb_words  = 0;
        out_ready = 1'b1;
        in_data   = 8'($urandom);
        in_valid  = 1'b1;
        sent      = 0;
        cyc       = 0;
        while (sent < 1000 && cyc < 70000) begin
            #1;
            if (in_ready) begin
                lb_sent_q.push_back(in_data);
                sent++;
                step();
                in_data = 8'($urandom);
            end else begin
                step();
            end
            cyc++;
        end
        in_valid = 1'b0;
        drain(1'b0);
        check("lb_words_decoded", 32'(lb_words), 1000);
        lb_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
